pmeas: RTL and testbench

Pulse-train measurement stage that sits directly downstream of the pulse generator. It consumes the generator's pulse output (pls) and sync output (sync_out, wired to this block's sync_in). For each full pulse period it measures three values in clock cycles: period, high time, and phase offset from the last sync. Each measurement is delivered through a valid/ready result port, with timeout and overflow flags.

---
 rtl/pmeas.sv | 145 ++++++++++++++
 tb/tb_pmeas.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmeas.sv
// Pulse-train measurement stage: measures period, high time and phase offset
// from the last sync for every full pulse period, delivered on a valid/ready
// result port with a one-cycle timeout pulse and a sticky overflow flag.
module pmeas #(
  parameter int P_CNT_W       = 16,
  parameter int P_TIMEOUT_CNT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync_in,
  input  logic               pls,
  input  logic               res_ready,
  output logic               res_valid,
  output logic [P_CNT_W-1:0] res_period,
  output logic [P_CNT_W-1:0] res_high,
  output logic [P_CNT_W-1:0] res_phase,
  output logic               res_phase_ok,
  output logic               timeout,
  output logic               ovf
);

  localparam logic [P_CNT_W-1:0] CNT_ONES = '1;
  localparam logic [P_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [P_CNT_W-1:0] CNT_ONE  = {{(P_CNT_W-1){1'b0}}, 1'b1};

  // An out-of-range timeout falls back to the largest count the counters hold,
  // which also guarantees per_cnt can never wrap.
  localparam bit TO_LEGAL = (P_TIMEOUT_CNT >= 2) &&
                            (longint'(P_TIMEOUT_CNT) <= longint'(CNT_ONES));
  localparam logic [P_CNT_W-1:0] TO_CNT = TO_LEGAL ? P_CNT_W'(P_TIMEOUT_CNT) : CNT_ONES;

  typedef enum logic {S_IDLE, S_MEAS} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               pls_d;
  logic               rise;
  logic [P_CNT_W-1:0] ph_cnt;
  logic               ph_seen;
  logic [P_CNT_W-1:0] per_cnt;
  logic [P_CNT_W-1:0] hi_cnt;
  logic [P_CNT_W-1:0] start_phase;
  logic               start_ok;
  logic               complete;
  logic               to_hit;
  logic               load;

  assign rise = pls & ~pls_d;
  assign load = complete & (~res_valid | res_ready);

  // Delay pls by one cycle for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pls_d <= 1'b0;
    else     pls_d <= pls;
  end

  // Phase tracker: cycles since the last sync, saturating, plus a seen flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_cnt  <= CNT_ZERO;
      ph_seen <= 1'b0;
    end else if (sync_in) begin
      ph_cnt  <= CNT_ZERO;
      ph_seen <= 1'b1;
    end else if (ph_cnt != CNT_ONES) begin
      ph_cnt  <= ph_cnt + CNT_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus completion/timeout decode for the current cycle.
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (rise) begin
          complete = 1'b1;
        end else if (per_cnt == TO_CNT) begin
          to_hit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Period/high counters; every rise (re)starts a period and latches its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt     <= CNT_ZERO;
      hi_cnt      <= CNT_ZERO;
      start_phase <= CNT_ZERO;
      start_ok    <= 1'b0;
    end else if (rise) begin
      per_cnt     <= CNT_ONE;
      hi_cnt      <= CNT_ONE;
      start_phase <= ph_cnt;
      start_ok    <= ph_seen;
    end else if (state == S_MEAS && !to_hit) begin
      per_cnt <= per_cnt + CNT_ONE;
      if (pls && hi_cnt != CNT_ONES) hi_cnt <= hi_cnt + CNT_ONE;
    end
  end

  // Result registers: load on completion when free or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_period   <= CNT_ZERO;
      res_high     <= CNT_ZERO;
      res_phase    <= CNT_ZERO;
      res_phase_ok <= 1'b0;
    end else if (load) begin
      res_valid    <= 1'b1;
      res_period   <= per_cnt;
      res_high     <= hi_cnt;
      res_phase    <= start_phase;
      res_phase_ok <= start_ok;
    end else if (res_ready) begin
      res_valid    <= 1'b0;
    end
  end

  // Timeout pulse one cycle after the limit is hit; sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (complete && !load) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pmeas.sv
// Self-checking bench for pmeas: two instances (long and short timeout) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_pmeas;

  localparam int W = 16;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic sync_in   = 1'b0;
  logic pls       = 1'b0;
  logic res_ready = 1'b0;

  logic         res_valid    [2];
  logic [W-1:0] res_period   [2];
  logic [W-1:0] res_high     [2];
  logic [W-1:0] res_phase    [2];
  logic         res_phase_ok [2];
  logic         timeout      [2];
  logic         ovf          [2];

  pmeas #(.P_CNT_W(W), .P_TIMEOUT_CNT(1024)) dut_long (
    .clk(clk), .rst(rst), .sync_in(sync_in), .pls(pls), .res_ready(res_ready),
    .res_valid(res_valid[0]), .res_period(res_period[0]), .res_high(res_high[0]),
    .res_phase(res_phase[0]), .res_phase_ok(res_phase_ok[0]),
    .timeout(timeout[0]), .ovf(ovf[0])
  );

  pmeas #(.P_CNT_W(W), .P_TIMEOUT_CNT(16)) dut_short (
    .clk(clk), .rst(rst), .sync_in(sync_in), .pls(pls), .res_ready(res_ready),
    .res_valid(res_valid[1]), .res_period(res_period[1]), .res_high(res_high[1]),
    .res_phase(res_phase[1]), .res_phase_ok(res_phase_ok[1]),
    .timeout(timeout[1]), .ovf(ovf[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: absolute cycle numbers since reset release, per instance.
  int to_lim [2] = '{1024, 16};
  int cyc        = 0;
  int last_sync  = -1;
  bit prev_pls   = 1'b0;
  bit m_inper [2];
  int m_start [2];
  int m_high  [2];
  int m_sphase[2];
  bit m_sok   [2];
  bit m_valid [2];
  int m_per   [2];
  int m_hi    [2];
  int m_ph    [2];
  bit m_ok    [2];
  bit m_ovf   [2];
  bit m_to    [2];

  task automatic checkOutput(input string name, input int inst,
                             input longint actual, input longint expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0d, expected %0d",
               name, inst, $time, actual, expected);
    end
  endtask

  // One stimulus cycle: drive inputs, let one rising edge sample them.
  task automatic applyStimulus(input bit s, input bit p, input bit r);
    sync_in   = s;
    pls       = p;
    res_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Generator-style train: pls high for hi cycles from roff, sync at spos.
  task automatic runTrain(input int per, input int hi, input int roff, input int spos,
                          input bit sen, input int ncyc, input bit rdy, input int kstart);
    for (int n = 0; n < ncyc; n++) begin
      int k;
      bit p;
      bit s;
      k = (kstart + n) % per;
      p = (k >= roff) && (k < roff + hi);
      s = sen && (k == spos);
      applyStimulus(s, p, rdy);
    end
  endtask

  task automatic checkResult(input int inst, input bit v, input int per,
                             input int hi, input int ph, input bit ok);
    checkOutput("lit_res_valid", inst, res_valid[inst], v);
    checkOutput("lit_res_period", inst, res_period[inst], per);
    checkOutput("lit_res_high", inst, res_high[inst], hi);
    checkOutput("lit_res_phase", inst, res_phase[inst], ph);
    checkOutput("lit_res_phase_ok", inst, res_phase_ok[inst], ok);
  endtask

  // Behavioural model: periods are differences of rise times, high time is a
  // count of high samples, phase is distance from the sync that preceded it.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc       = 0;
        last_sync = -1;
        prev_pls  = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_inper[i] = 0; m_start[i] = 0; m_high[i] = 0; m_sphase[i] = 0;
          m_sok[i] = 0; m_valid[i] = 0; m_per[i] = 0; m_hi[i] = 0;
          m_ph[i] = 0; m_ok[i] = 0; m_ovf[i] = 0; m_to[i] = 0;
        end
      end else begin
        bit rise_m;
        bit seen;
        int ph;
        rise_m = pls && !prev_pls;
        ph     = cyc - ((last_sync < 0) ? 0 : last_sync + 1);
        if (ph > 65535) ph = 65535;
        seen   = (last_sync >= 0);
        for (int i = 0; i < 2; i++) begin
          bit done;
          done    = 0;
          m_to[i] = 0;
          if (m_inper[i]) begin
            if (rise_m) done = 1;
            else if (cyc - m_start[i] == to_lim[i]) begin
              m_to[i]    = 1;
              m_inper[i] = 0;
            end
          end
          if (done) begin
            if (!m_valid[i] || res_ready) begin
              m_valid[i] = 1;
              m_per[i]   = cyc - m_start[i];
              m_hi[i]    = m_high[i];
              m_ph[i]    = m_sphase[i];
              m_ok[i]    = m_sok[i];
            end else begin
              m_ovf[i] = 1;
            end
          end else if (m_valid[i] && res_ready) begin
            m_valid[i] = 0;
          end
          if (rise_m) begin
            m_inper[i]  = 1;
            m_start[i]  = cyc;
            m_high[i]   = 0;
            m_sphase[i] = ph;
            m_sok[i]    = seen;
          end
          if (m_inper[i] && pls) m_high[i]++;
        end
        if (sync_in) last_sync = cyc;
        prev_pls = pls;
        cyc++;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checkOutput("res_valid", i, res_valid[i], m_valid[i]);
        checkOutput("timeout", i, timeout[i], m_to[i]);
        checkOutput("ovf", i, ovf[i], m_ovf[i]);
        if (m_valid[i]) begin
          checkOutput("res_period", i, res_period[i], m_per[i]);
          checkOutput("res_high", i, res_high[i], m_hi[i]);
          checkOutput("res_phase", i, res_phase[i], m_ph[i]);
          checkOutput("res_phase_ok", i, res_phase_ok[i], m_ok[i]);
        end
      end
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checkResult(i, 0, 0, 0, 0, 0);
      checkOutput("lit_timeout", i, timeout[i], 0);
      checkOutput("lit_ovf", i, ovf[i], 0);
    end
    rst = 1'b0;

    // Period 10, high 5, sync one cycle before each rise.
    runTrain(10, 5, 0, 9, 1, 50, 1, 0);
    runTrain(10, 5, 0, 9, 1, 1, 0, 0);
    checkResult(0, 1, 10, 5, 0, 1);
    checkResult(1, 1, 10, 5, 0, 1);

    // Consumer stalls: held result, later completions dropped.
    runTrain(10, 5, 0, 9, 1, 29, 0, 1);
    checkResult(0, 1, 10, 5, 0, 1);
    checkOutput("lit_ovf", 0, ovf[0], 1);
    checkOutput("lit_ovf", 1, ovf[1], 1);
    runTrain(10, 5, 0, 9, 1, 20, 1, 0);

    // Period 20, 25% duty, rise 5 cycles into the frame, sync 1 cycle before.
    runTrain(20, 5, 5, 19, 1, 80, 1, 0);
    runTrain(20, 5, 5, 19, 1, 6, 0, 0);
    checkResult(0, 1, 20, 5, 5, 1);
    checkOutput("lit_res_valid", 1, res_valid[1], 0);
    runTrain(20, 5, 5, 19, 1, 14, 1, 6);

    // One rise then pls stuck low: short instance times out 16 cycles later.
    applyStimulus(0, 1, 1);
    for (int n = 0; n < 15; n++) applyStimulus(0, 0, 1);
    checkOutput("lit_timeout", 1, timeout[1], 0);
    applyStimulus(0, 0, 1);
    checkOutput("lit_timeout", 1, timeout[1], 1);
    checkOutput("lit_timeout", 0, timeout[0], 0);
    applyStimulus(0, 0, 1);
    checkOutput("lit_timeout", 1, timeout[1], 0);
    for (int n = 0; n < 10; n++) applyStimulus(0, 0, 1);
    runTrain(8, 4, 0, 0, 0, 9, 0, 0);
    checkOutput("lit_res_valid", 1, res_valid[1], 1);
    checkOutput("lit_res_period", 1, res_period[1], 8);
    checkOutput("lit_res_high", 1, res_high[1], 4);

    // Reset mid-period with a result pending.
    runTrain(8, 4, 0, 0, 0, 3, 0, 1);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkResult(i, 0, 0, 0, 0, 0);
      checkOutput("lit_timeout", i, timeout[i], 0);
      checkOutput("lit_ovf", i, ovf[i], 0);
    end
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    rst = 1'b0;

    // No sync since reset: first rise only starts, phase is the running count.
    runTrain(10, 5, 0, 0, 0, 1, 1, 0);
    checkOutput("lit_res_valid", 0, res_valid[0], 0);
    checkOutput("lit_res_valid", 1, res_valid[1], 0);
    runTrain(10, 5, 0, 0, 0, 10, 0, 1);
    checkResult(0, 1, 10, 5, 0, 0);
    runTrain(10, 5, 0, 0, 0, 29, 1, 1);
    for (int n = 0; n < 4; n++) applyStimulus(0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
